// File: rtl/gen_relojes_pkg.sv
// -----------------------------------------------------------------------------
// gen_relojes_pkg
// Shared constants and helpers for the parametrised clock/strobe generator.
//   GR_STAGES_DEF : default number of divided outputs
//   GR_STAGES_MAX : largest supported number of divided outputs
//   gr_clog2()    : ceiling log2, used to size the stage-select input
// -----------------------------------------------------------------------------
package gen_relojes_pkg;

   localparam int GR_STAGES_DEF = 5;
   localparam int GR_STAGES_MAX = 16;

   // Smallest w with 2^w >= value (returns 0 for value <= 1).
   function automatic int gr_clog2(input int value);
      int res;
      res = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage : gen_relojes_pkg

// File: rtl/etapa_divisora.sv
// -----------------------------------------------------------------------------
// etapa_divisora
// One toggle stage of the binary divider chain. The stage flips when its
// toggle input is high; the carry-out tells the next stage that this one is
// about to wrap from 1 to 0.
// Ports:
//   clk      : fast clock
//   rst_n    : asynchronous active-low reset
//   sclr_i   : synchronous clear, overrides toggle
//   t_i      : toggle request (all lower stages are 1 and counting is enabled)
//   q_o      : registered stage output (divided clock)
//   q_d_o    : next-state value of the stage, for registered taps upstream
//   rise_o   : one-cycle pulse in the cycle q_o first reads 1
//   carry_o  : toggle request for the next stage (t_i && q)
// -----------------------------------------------------------------------------
module etapa_divisora
   import gen_relojes_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic sclr_i,
   input  logic t_i,
   output logic q_o,
   output logic q_d_o,
   output logic rise_o,
   output logic carry_o
);

   logic q_q, q_d;
   logic rise_q, rise_d;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      q_d    = q_q;
      rise_d = 1'b0;
      if (sclr_i) begin
         q_d = 1'b0;
      end else if (t_i) begin
         q_d    = ~q_q;
         rise_d = ~q_q;   // a toggle from 0 is a rising edge of the divided clock
      end
   end

   // NOTE: state registers use non-blocking assignments so all stages update
   // together from the values they had before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q    <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         rise_q <= rise_d;
      end
   end

   assign q_o     = q_q;
   assign q_d_o   = q_d;
   assign rise_o  = rise_q;
   assign carry_o = t_i & q_q;

endmodule : etapa_divisora

// File: rtl/generador_de_relojes_param.sv
// -----------------------------------------------------------------------------
// generador_de_relojes_param
// Synchronous clock/strobe generator: STAGES binary-divided clocks from CLK,
// one rising-edge strobe per stage, a wrap pulse and one selectable output.
// Ports:
//   CLK      : fast clock, everything updates on its rising edge
//   RESET_L  : asynchronous active-low reset
//   EN       : count enable; 0 freezes every divider
//   SCLR     : synchronous clear/realign, wins over EN
//   SEL      : stage index routed to OUT_SEL (out-of-range gives 0)
//   DIV      : divided clocks, DIV[k] = CLK / 2^(k+1)
//   RISE     : one-cycle strobe when DIV[k] first reads 1
//   WRAP     : one-cycle strobe when the count rolls from all-ones to zero
//   OUT_SEL  : registered copy of the selected stage, aligned with DIV
// -----------------------------------------------------------------------------
module generador_de_relojes_param
   import gen_relojes_pkg::*;
#(
   parameter int STAGES = GR_STAGES_DEF,
   parameter int SEL_W  = (gr_clog2(STAGES) > 0) ? gr_clog2(STAGES) : 1
) (
   input  logic              CLK,
   input  logic              RESET_L,
   input  logic              EN,
   input  logic              SCLR,
   input  logic [SEL_W-1:0]  SEL,
   output logic [STAGES-1:0] DIV,
   output logic [STAGES-1:0] RISE,
   output logic              WRAP,
   output logic              OUT_SEL
);

   // Toggle chain: stage k toggles when EN is high and stages 0..k-1 are all 1.
   // The last element is high exactly when the whole count is about to wrap.
   logic [STAGES:0]   t_chain;
   logic [STAGES-1:0] cnt_d;
   logic              wrap_q, wrap_d;
   logic              out_sel_q, out_sel_d;

   assign t_chain[0] = EN;

   for (genvar k = 0; k < STAGES; k++) begin : g_etapa
      etapa_divisora u_etapa (
         .clk     (CLK),
         .rst_n   (RESET_L),
         .sclr_i  (SCLR),
         .t_i     (t_chain[k]),
         .q_o     (DIV[k]),
         .q_d_o   (cnt_d[k]),
         .rise_o  (RISE[k]),
         .carry_o (t_chain[k+1])
      );
   end

   always_comb begin
      wrap_d    = t_chain[STAGES] & ~SCLR;
      // Tap the next-state count so OUT_SEL lands on the same edge as DIV.
      out_sel_d = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         if (SEL == SEL_W'(k)) begin
            out_sel_d = cnt_d[k];
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         wrap_q    <= 1'b0;
         out_sel_q <= 1'b0;
      end else begin
         wrap_q    <= wrap_d;
         out_sel_q <= out_sel_d;
      end
   end

   assign WRAP    = wrap_q;
   assign OUT_SEL = out_sel_q;

endmodule : generador_de_relojes_param

// File: tb/tb_generador_de_relojes_param.sv
// -----------------------------------------------------------------------------
// tb_generador_de_relojes_param
// Self-checking bench for the clock/strobe generator with STAGES=5. A counter
// model computed with plain arithmetic predicts every output after each edge.
// -----------------------------------------------------------------------------
module tb_generador_de_relojes_param;

   localparam int STAGES = 5;
   localparam int SEL_W  = 3;
   localparam int MODN   = 1 << STAGES;
   localparam int ALL1   = MODN - 1;

   logic              CLK     = 1'b0;
   logic              RESET_L = 1'b0;
   logic              EN      = 1'b0;
   logic              SCLR    = 1'b0;
   logic [SEL_W-1:0]  SEL     = '0;
   logic [STAGES-1:0] DIV;
   logic [STAGES-1:0] RISE;
   logic              WRAP;
   logic              OUT_SEL;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state and expected outputs.
   int m_cnt = 0;
   int e_div = 0, e_rise = 0, e_wrap = 0, e_out = 0;

   generador_de_relojes_param #(.STAGES(STAGES), .SEL_W(SEL_W)) dut (
      .CLK     (CLK),
      .RESET_L (RESET_L),
      .EN      (EN),
      .SCLR    (SCLR),
      .SEL     (SEL),
      .DIV     (DIV),
      .RISE    (RISE),
      .WRAP    (WRAP),
      .OUT_SEL (OUT_SEL)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".div"},     int'(DIV),     e_div);
      check({tag, ".rise"},    int'(RISE),    e_rise);
      check({tag, ".wrap"},    int'(WRAP),    e_wrap);
      check({tag, ".out_sel"}, int'(OUT_SEL), e_out);
   endtask

   task automatic model_reset();
      m_cnt = 0; e_div = 0; e_rise = 0; e_wrap = 0; e_out = 0;
   endtask

   // Behaviour of one rising edge, straight from the counting rules.
   task automatic model_edge(input bit en, input bit sclr, input int sel);
      int nxt;
      if (sclr)    nxt = 0;
      else if (en) nxt = (m_cnt + 1) % MODN;
      else         nxt = m_cnt;
      e_rise = (en && !sclr) ? (nxt & ~m_cnt & ALL1) : 0;
      e_wrap = (en && !sclr && m_cnt == ALL1) ? 1 : 0;
      e_out  = (sel < STAGES) ? ((nxt >> sel) & 1) : 0;
      m_cnt  = nxt;
      e_div  = nxt;
   endtask

   // Inputs change on the falling edge, outputs are checked on the next one.
   task automatic step(input bit en, input bit sclr, input int sel, input string tag);
      EN   = en;
      SCLR = sclr;
      SEL  = SEL_W'(sel);
      @(posedge CLK);
      model_edge(en, sclr, sel);
      @(negedge CLK);
      check_all(tag);
   endtask

   initial begin
      int high_cnt [STAGES];
      int runs [$];
      int run;
      int wraps [$];

      // ---------------- reset and start-up ----------------
      repeat (2) @(negedge CLK);
      model_reset();
      check_all("reset");
      RESET_L = 1'b1;
      step(1, 0, 0, "start1");
      check("start1.div_const",  int'(DIV),  1);
      check("start1.rise_const", int'(RISE), 1);
      step(1, 0, 0, "start2");
      check("start2.div_const",  int'(DIV),  2);
      check("start2.rise_const", int'(RISE), 2);
      step(1, 0, 0, "start3");
      step(1, 0, 0, "start4");
      check("start4.rise_const", int'(RISE), 4);

      // ---------------- full period ----------------
      step(1, 1, 0, "realign");
      for (int k = 0; k < STAGES; k++) high_cnt[k] = 0;
      run = 0;
      for (int e = 1; e <= 2 * MODN; e++) begin
         step(1, 0, e % 8, "period");
         for (int k = 0; k < STAGES; k++) if (DIV[k]) high_cnt[k]++;
         if (DIV[4]) run++;
         else if (run > 0) begin runs.push_back(run); run = 0; end
         if (WRAP) wraps.push_back(e);
      end
      check("period.div4_runs", runs.size(), 2);
      foreach (runs[i]) check("period.div4_run_len", runs[i], 16);
      check("period.wrap_count", wraps.size(), 2);
      if (wraps.size() == 2) begin
         check("period.wrap_edge_a", wraps[0], 32);
         check("period.wrap_edge_b", wraps[1], 64);
      end
      for (int k = 0; k < STAGES; k++) check("period.duty", high_cnt[k], MODN);

      // ---------------- freeze ----------------
      repeat (7) step(1, 0, 1, "to7");
      check("freeze.pre_div", int'(DIV), 7);
      repeat (3) begin
         step(0, 0, 1, "freeze");
         check("freeze.div_const",  int'(DIV),  7);
         check("freeze.rise_const", int'(RISE), 0);
      end
      step(1, 0, 1, "unfreeze");
      check("unfreeze.div_const",  int'(DIV),  8);
      check("unfreeze.rise_const", int'(RISE), 8);

      // ---------------- clear priority ----------------
      repeat (23) step(1, 0, 3, "to31");
      check("clr.pre_div", int'(DIV), 31);
      step(1, 1, 3, "clr");
      check("clr.div_const",  int'(DIV),  0);
      check("clr.wrap_const", int'(WRAP), 0);
      step(1, 0, 3, "post_clr");
      check("post_clr.div_const", int'(DIV), 1);

      // ---------------- select ----------------
      repeat (16) step(1, 0, 2, "sel2");
      repeat (8)  begin
         step(1, 0, 6, "sel6");
         check("sel6.zero", int'(OUT_SEL), 0);
      end
      repeat (24) step($urandom_range(0, 3) != 0, 0, $urandom_range(0, 7), "sel_mix");

      // ---------------- async reset mid-count ----------------
      for (int i = 0; i < 2 * MODN && m_cnt != 22; i++) step(1, 0, 4, "to22");
      check("arst.pre_div", int'(DIV), 22);
      #2 RESET_L = 1'b0;
      #1;
      model_reset();
      check_all("arst");
      @(negedge CLK);
      RESET_L = 1'b1;
      step(1, 0, 0, "arst_resume");
      check("arst_resume.div_const", int'(DIV), 1);

      // ---------------- randomized traffic ----------------
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            #3 RESET_L = 1'b0;
            #1;
            model_reset();
            check_all("rnd_arst");
            @(negedge CLK);
            RESET_L = 1'b1;
         end
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 7), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_generador_de_relojes_param
